// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM read arbiter: FSM states, requester IDs and the
// read-return tag carried alongside each issued ROM address.
package rom_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  typedef struct packed {
    logic vld;
    logic id;
    logic last;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

  // Round robin: on a tie the requester that did not own the previous burst wins.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_owner);
    if (req0 && req1) return ~last_owner;
    if (req0)         return ID_REQ0;
    return ID_REQ1;
  endfunction

endpackage

// File: rtl/rom_rd_tag_pipe.sv
// Delays the {vld,id,last} tag of each issued ROM address by the ROM latency so
// it lines up with rom_q; decodes the output stage into per-requester strobes.
module rom_rd_tag_pipe
  import rom_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output logic rd_vld0_c,
  output logic rd_vld1_c,
  output logic rd_last_c,
  output logic pipe_busy_c
);

  tag_t tag_q [DEPTH];
  tag_t tag_d [DEPTH];

  always_comb begin
    tag_d[0] = tag_in;
    for (int i = 1; i < int'(DEPTH); i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Clear drops beats already in flight so nothing is returned after a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  always_comb begin
    rd_vld0_c   = tag_q[DEPTH-1].vld && (tag_q[DEPTH-1].id == ID_REQ0);
    rd_vld1_c   = tag_q[DEPTH-1].vld && (tag_q[DEPTH-1].id == ID_REQ1);
    rd_last_c   = tag_q[DEPTH-1].vld && tag_q[DEPTH-1].last;
    pipe_busy_c = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      pipe_busy_c = pipe_busy_c | tag_q[i].vld;
    end
  end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Shares one registered-address ROM between two burst requesters: round-robin
// grant at burst boundaries, sequential wrapping addresses, tagged read return.
module rom_rd_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] len0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] len1,
  output logic          gnt1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q,
  output logic [DW-1:0] rd_data,
  output logic          rd_vld0,
  output logic          rd_vld1,
  output logic          rd_last,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          win_c;
  tag_t          tag_in_c;
  logic          pipe_busy_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rom_addr_q   <= '0;
      cnt_q        <= '0;
      owner_q      <= ID_REQ0;
      last_owner_q <= ID_REQ1;
      gnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
    end
  end

  // Next state: arbitrate in IDLE, walk the address counter in BURST.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = '0;
    win_c        = rr_pick(req0, req1, last_owner_q);

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d      = ST_BURST;
          gnt_d[win_c] = 1'b1;
          rom_addr_d   = win_c ? addr1 : addr0;
          cnt_d        = win_c ? len1 : len0;
          owner_d      = win_c;
          last_owner_d = win_c;
        end
      end
      ST_BURST: begin
        // The IDLE cycle after the final beat is the mandatory bubble.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          rom_addr_d = rom_addr_q + AW'(1);
          cnt_d      = cnt_q - AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tag_in_c      = '0;
    tag_in_c.vld  = (state_q == ST_BURST);
    tag_in_c.id   = owner_q;
    tag_in_c.last = (cnt_q == '0);
  end

  rom_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .tag_in      (tag_in_c),
    .rd_vld0_c   (rd_vld0),
    .rd_vld1_c   (rd_vld1),
    .rd_last_c   (rd_last),
    .pipe_busy_c (pipe_busy_c)
  );

  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign rom_addr = rom_addr_q;
  assign rd_data  = rom_q;
  assign busy     = (state_q != ST_IDLE) || pipe_busy_c;

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Bench for rom_rd_arbiter: two instances (ROM latency 1 and 3) share stimulus
// and are compared every cycle against a burst-schedule reference model.
module tb_rom_rd_arbiter;

  localparam int MAXC = 40000;

  typedef struct packed {
    bit       vld;
    bit       id;
    bit       last;
    bit [7:0] addr;
  } iss_t;

  typedef struct {
    bit       id;
    bit [7:0] addr;
    bit [7:0] len;
    int       beats;
    bit [7:0] first;
    bit [7:0] lastd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = '0, len0 = '0, addr1 = '0, len1 = '0;

  logic       gnt0_1, gnt1_1, rd_vld0_1, rd_vld1_1, rd_last_1, busy_1;
  logic [7:0] rom_addr_1, rom_q_1, rd_data_1;
  logic       gnt0_3, gnt1_3, rd_vld0_3, rd_vld1_3, rd_last_3, busy_3;
  logic [7:0] rom_addr_3, rom_q_3, rd_data_3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rom_rd_arbiter #(.RD_LAT(1), .AW(8), .DW(8)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .len0(len0), .gnt0(gnt0_1),
    .req1(req1), .addr1(addr1), .len1(len1), .gnt1(gnt1_1),
    .rom_addr(rom_addr_1), .rom_q(rom_q_1), .rd_data(rd_data_1),
    .rd_vld0(rd_vld0_1), .rd_vld1(rd_vld1_1), .rd_last(rd_last_1), .busy(busy_1));

  rom_rd_arbiter #(.RD_LAT(3), .AW(8), .DW(8)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .len0(len0), .gnt0(gnt0_3),
    .req1(req1), .addr1(addr1), .len1(len1), .gnt1(gnt1_3),
    .rom_addr(rom_addr_3), .rom_q(rom_q_3), .rd_data(rd_data_3),
    .rd_vld0(rd_vld0_3), .rd_vld1(rd_vld1_3), .rd_last(rd_last_3), .busy(busy_3));

  // ROM models: q = ~addr, registered address, RD_LAT cycles to q.
  logic [7:0] q1_p;
  logic [7:0] q3_p [3];
  always @(posedge clk) begin
    q1_p    <= ~rom_addr_1;
    q3_p[0] <= ~rom_addr_3;
    q3_p[1] <= q3_p[0];
    q3_p[2] <= q3_p[1];
  end
  assign rom_q_1 = q1_p;
  assign rom_q_3 = q3_p[2];

  // Reference model: a schedule of which address is issued in which cycle.
  int       cyc    = 0;
  int       free_c = 0;
  int       kill   = 0;
  bit       lo     = 1'b1;
  iss_t     iss    [MAXC];
  bit [1:0] gnt_m  [MAXC];
  bit [7:0] addr_m [MAXC];

  always @(posedge clk) begin : model
    int c, blen;
    bit w;
    bit [7:0] base;
    c = cyc;
    if (c + 300 >= MAXC) begin
      $display("FAIL model_range cyc=%0d got=out_of_table want=<%0d", c, MAXC - 300);
      $fatal(1);
    end
    if (rst) begin
      for (int i = c + 1; i < c + 300; i++) begin
        iss[i]   = '0;
        gnt_m[i] = '0;
      end
      free_c      = c + 1;
      kill        = c + 1;
      lo          = 1'b1;
      addr_m[c+1] = 8'h00;
    end else begin
      if (c >= free_c && (req0 || req1)) begin
        w    = (req0 && req1) ? ~lo : (req0 ? 1'b0 : 1'b1);
        lo   = w;
        blen = w ? int'(len1) + 1 : int'(len0) + 1;
        base = w ? addr1 : addr0;
        gnt_m[c+1][w] = 1'b1;
        for (int j = 0; j < blen; j++) begin
          iss[c+1+j].vld  = 1'b1;
          iss[c+1+j].id   = w;
          iss[c+1+j].last = (j == blen - 1);
          iss[c+1+j].addr = base + 8'(j);
        end
        free_c = c + blen + 1;
      end
      addr_m[c+1] = iss[c+1].vld ? iss[c+1].addr : addr_m[c];
    end
    cyc = c + 1;
  end

  task automatic check(input string nm, input int lat, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lat=%0d cyc=%0d got=%0h want=%0h", nm, lat, cyc, act, exp);
    end
  endtask

  task automatic chk_dut(input int lat, input logic g0, input logic g1,
                         input logic [7:0] ra, input logic [7:0] rd,
                         input logic v0, input logic v1, input logic lst,
                         input logic bsy, input logic [1:0] pg);
    iss_t     e;
    bit       eb;
    bit [7:0] ed;
    int       k;
    k = cyc - lat;
    e = '0;
    if (k >= 0 && k >= kill) e = iss[k];
    eb = iss[cyc].vld;
    for (int i = cyc - lat; i < cyc; i++)
      if (i >= 0 && i >= kill && iss[i].vld) eb = 1'b1;
    ed = ~e.addr;
    check("gnt", lat, 32'({g1, g0}), 32'(gnt_m[cyc]));
    check("rom_addr", lat, 32'(ra), 32'(addr_m[cyc]));
    check("rd_tag", lat, 32'({v1, v0, lst}),
          32'({e.vld && e.id, e.vld && !e.id, e.vld && e.last}));
    if (e.vld) check("rd_data", lat, 32'(rd), 32'(ed));
    check("busy", lat, 32'(bsy), 32'(eb));
    check("vld_excl", lat, 32'(v0 & v1), 32'(0));
    check("last_wo_vld", lat, 32'(lst & ~(v0 | v1)), 32'(0));
    check("gnt_pulse", lat, 32'({g1, g0} & pg), 32'(0));
  endtask

  logic [1:0] pg1 = '0, pg3 = '0;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk_dut(1, gnt0_1, gnt1_1, rom_addr_1, rd_data_1, rd_vld0_1, rd_vld1_1,
              rd_last_1, busy_1, pg1);
      chk_dut(3, gnt0_3, gnt1_3, rom_addr_3, rd_data_3, rd_vld0_3, rd_vld1_3,
              rd_last_3, busy_3, pg3);
      pg1 = {gnt1_1, gnt0_1};
      pg3 = {gnt1_3, gnt0_3};
    end
  end

  task automatic wait_idle();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!busy_1 && !busy_3) return;
    end
    check("idle_timeout", 0, 32'(busy_1 | busy_3), 32'(0));
  endtask

  // Single burst on one requester; req dropped the cycle after its grant.
  task automatic run_burst(input vec_t v);
    bit       got;
    int       beats, last_at;
    bit [7:0] first, lastd;
    got = 1'b0; beats = 0; last_at = 0; first = '0; lastd = '0;
    @(posedge clk); #1;
    if (v.id) begin req1 = 1'b1; addr1 = v.addr; len1 = v.len; end
    else      begin req0 = 1'b1; addr0 = v.addr; len0 = v.len; end
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (v.id ? gnt1_1 : gnt0_1) got = 1'b1;
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (v.id ? rd_vld1_1 : rd_vld0_1) begin
        if (beats == 0) first = rd_data_1;
        lastd = rd_data_1;
        beats++;
        if (rd_last_1) last_at = beats;
      end
      if (!busy_1 && !busy_3) break;
    end
    check("tbl_gnt_seen", 0, 32'(got), 32'(1));
    check("tbl_beats", 0, 32'(beats), 32'(v.beats));
    check("tbl_first", 0, 32'(first), 32'(v.first));
    check("tbl_lastd", 0, 32'(lastd), 32'(v.lastd));
    check("tbl_last_at", 0, 32'(last_at), 32'(v.beats));
    wait_idle();
  endtask

  // Both requesters raised together; returns the grant cycles of each.
  task automatic contest(output int g0, output int g1);
    bit d0, d1;
    g0 = -1; g1 = -1;
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 8'h30; len0 = 8'd2;
    req1 = 1'b1; addr1 = 8'h40; len1 = 8'd1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      d0 = gnt0_1; d1 = gnt1_1;
      if (d0) g0 = cyc;
      if (d1) g1 = cyc;
      @(posedge clk); #1;
      if (d0) req0 = 1'b0;
      if (d1) req1 = 1'b0;
      if (g0 >= 0 && g1 >= 0) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  vec_t tbl [4];
  int   ga, gb;

  initial begin
    tbl[0] = '{id: 1'b0, addr: 8'h0A, len: 8'h03, beats: 4,   first: 8'hF5, lastd: 8'hF2};
    tbl[1] = '{id: 1'b1, addr: 8'hFE, len: 8'h03, beats: 4,   first: 8'h01, lastd: 8'hFE};
    tbl[2] = '{id: 1'b0, addr: 8'h20, len: 8'hFF, beats: 256, first: 8'hDF, lastd: 8'hE0};
    tbl[3] = '{id: 1'b0, addr: 8'h55, len: 8'h00, beats: 1,   first: 8'hAA, lastd: 8'hAA};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_addr", 1, 32'(rom_addr_1), 32'(0));
    check("rst_busy", 3, 32'(busy_3), 32'(0));

    for (int i = 0; i < 4; i++) run_burst(tbl[i]);

    // Round robin from reset: req0 first, req1 after L0+1 cycles, then req0 again.
    pulse_rst();
    contest(ga, gb);
    check("rr_gap_first", 0, 32'(gb - ga), 32'(4));
    contest(ga, gb);
    check("rr_gap_third", 0, 32'(gb - ga), 32'(4));

    // Reset two cycles into an 8-beat burst.
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 8'h80; len0 = 8'd7;
    ga = 0;
    for (int t = 0; t < 20 && ga == 0; t++) begin
      @(negedge clk);
      if (gnt0_1) ga = 1;
    end
    check("rstmid_gnt", 0, 32'(ga), 32'(1));
    @(posedge clk); #1 req0 = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_addr1", 1, 32'(rom_addr_1), 32'(0));
    check("rstmid_addr3", 3, 32'(rom_addr_3), 32'(0));
    check("rstmid_busy", 0, 32'({busy_1, busy_3}), 32'(0));
    for (int t = 0; t < 5; t++) begin
      check("rstmid_novld", 0, 32'({rd_vld0_1, rd_vld1_1, rd_last_1,
                                    rd_vld0_3, rd_vld1_3, rd_last_3}), 32'(0));
      @(negedge clk);
    end
    run_burst(tbl[0]);

    // Random traffic, including held requests and occasional resets.
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 299) == 0);
      req0  = ($urandom_range(0, 2) != 0);
      req1  = ($urandom_range(0, 2) != 0);
      addr0 = 8'($urandom);
      addr1 = 8'($urandom);
      len0  = ($urandom_range(0, 40) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      len1  = ($urandom_range(0, 40) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
    end
    @(posedge clk); #1;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
